// File: rtl/axil_xip_master.sv
// AXI4-Lite master: turns a single-outstanding request/response port into AXI4-Lite
// read/write transactions, with a watchdog and a drain state so a stalled slave cannot wedge it.
module axil_xip_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // Request / response port
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  rsp_timeout_o,
  // AXI4-Lite master
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [31:0]           rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    StIdle, StRdAddr, StRdData, StWrAddr, StWrResp, StRsp, StDrain
  } state_e;

  localparam bit                  WdogEn = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_WIDTH-1:0] ToLast = WdogEn ? TO_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  is_write_q, is_write_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                  rready_q, rready_d, bready_q, bready_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d, axi_done_q, axi_done_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  req_ready_q, req_ready_d, busy_q, busy_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  ar_hs, r_hs, b_hs, final_hs;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    is_write_d    = is_write_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    bready_d      = bready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    axi_done_d    = axi_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    // Channel handshakes run identically in the active states and in DRAIN.
    ar_hs = arvalid_q && arready_i;
    r_hs  = rready_q && rvalid_i;
    b_hs  = bready_q && bvalid_i;
    if (ar_hs) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (r_hs) rready_d = 1'b0;
    if (awvalid_q && awready_i) begin
      awvalid_d = 1'b0;
      aw_done_d = 1'b1;
    end
    if (wvalid_q && wready_i) begin
      wvalid_d = 1'b0;
      w_done_d = 1'b1;
    end
    if (is_write_q && aw_done_d && w_done_d && !axi_done_q && !bready_q) bready_d = 1'b1;
    if (b_hs) bready_d = 1'b0;
    final_hs = is_write_q ? b_hs : r_hs;
    if (final_hs) axi_done_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          wstrb_d    = req_wstrb_i;
          is_write_d = req_write_i;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          axi_done_d = 1'b0;
          cnt_d      = '0;
          if (req_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrAddr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdAddr;
          end
        end
      end
      StRdAddr, StRdData, StWrAddr, StWrResp: begin
        if (WdogEn) cnt_d = cnt_q + TO_WIDTH'(1);
        // A real response arriving in the last watchdog cycle beats the timeout.
        if (final_hs) begin
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = is_write_q ? bresp_i : rresp_i;
          rsp_rdata_d   = is_write_q ? 32'h0 : rdata_i;
          rsp_timeout_d = 1'b0;
          state_d       = StRsp;
        end else if (WdogEn && (cnt_q == ToLast)) begin
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = 2'b10;
          rsp_rdata_d   = 32'h0;
          rsp_timeout_d = 1'b1;
          state_d       = StDrain;
        end else if ((state_q == StRdAddr) && ar_hs) begin
          state_d = StRdData;
        end else if ((state_q == StWrAddr) && aw_done_d && w_done_d) begin
          state_d = StWrResp;
        end
      end
      StRsp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        if (rsp_ready_i) rsp_valid_d = 1'b0;
        if (axi_done_d && !rsp_valid_d) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      is_write_q    <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      bready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      axi_done_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      is_write_q    <= is_write_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      bready_q      <= bready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      axi_done_q    <= axi_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign awaddr_o      = addr_q;
  assign awvalid_o     = awvalid_q;
  assign wdata_o       = wdata_q;
  assign wstrb_o       = wstrb_q;
  assign wvalid_o      = wvalid_q;
  assign bready_o      = bready_q;
  assign araddr_o      = addr_q;
  assign arvalid_o     = arvalid_q;
  assign rready_o      = rready_q;
  assign busy_o        = busy_q;

endmodule
